// File: rtl/ifetch_queue.sv
// Fetch front end: owns the PC, issues one-cycle-latency reads, buffers {pc,inst} for decode.
// IRead to fetch_valid is 2 cycles; issue throttles on queue space, never on fetch_ready.
`timescale 1ns/1ps
module ifetch_queue #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    ADDR_SHIFT = 2
) (
  input  logic                         Clk,
  input  logic                         Reset,
  output logic [ADDR_WIDTH-1:0]        IAddr,
  output logic                         IRead,
  input  logic [DATA_WIDTH-1:0]        Inst,
  input  logic                         redirect,
  input  logic [ADDR_WIDTH-1:0]        redirect_target,
  output logic                         fetch_valid,
  input  logic                         fetch_ready,
  output logic [DATA_WIDTH-1:0]        fetch_inst,
  output logic [ADDR_WIDTH-1:0]        fetch_pc,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int              OCC_W    = $clog2(DEPTH+1);
  localparam int              PTR_W    = $clog2(DEPTH);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH-1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] inst;
  } entry_t;

  entry_t                q_mem [DEPTH];
  logic [PTR_W-1:0]      rd_ptr, wr_ptr;
  logic [OCC_W-1:0]      occ;
  logic [ADDR_WIDTH-1:0] pc, req_pc;
  logic                  inflight, drop;
  logic                  push, pop;
  logic [OCC_W:0]        committed;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // An in-flight read already owns a slot, so it counts against the free space.
  always_comb begin
    committed = {1'b0, occ} + {{OCC_W{1'b0}}, inflight};
    IRead     = !Reset && !redirect && (committed < {1'b0, OCC_FULL});
    push      = inflight && !drop && !redirect && !Reset;
    pop       = fetch_valid && fetch_ready && !redirect;
  end

  assign IAddr       = pc >> ADDR_SHIFT;
  assign fetch_valid = (occ != '0);
  assign occupancy   = occ;
  assign fetch_inst  = q_mem[rd_ptr].inst;
  assign fetch_pc    = q_mem[rd_ptr].pc;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc       <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
      drop     <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      occ      <= '0;
      for (int i = 0; i < DEPTH; i++) q_mem[i] <= '0;
    end else begin
      inflight <= IRead;
      drop     <= redirect;
      if (IRead) begin
        req_pc <= pc;
        pc     <= pc + ADDR_WIDTH'(4);
      end
      if (redirect) begin
        pc     <= redirect_target & ~ADDR_WIDTH'(3);
        rd_ptr <= '0;
        wr_ptr <= '0;
        occ    <= '0;
      end else begin
        if (push) begin
          q_mem[wr_ptr] <= '{pc: req_pc, inst: Inst};
          wr_ptr        <= next_ptr(wr_ptr);
        end
        if (pop) rd_ptr <= next_ptr(rd_ptr);
        occ <= occ + OCC_W'(push) - OCC_W'(pop);
      end
    end
  end

  a_no_overflow:  assert property (@(posedge Clk) disable iff (Reset) !(push && occ == OCC_FULL));
  a_no_underflow: assert property (@(posedge Clk) disable iff (Reset) !(pop && occ == '0));

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: directed table, corner sequences and a random run against a queue model.
`timescale 1ns/1ps
module tb_ifetch_queue;

  logic        Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        Reset, redirect, fetch_ready;
  logic [31:0] redirect_target;

  logic [31:0] iaddr_a, inst_a, finst_a, fpc_a;
  logic        iread_a, fvalid_a;
  logic [2:0]  occ_a;
  logic [31:0] iaddr_b, inst_b, finst_b, fpc_b;
  logic        iread_b, fvalid_b;
  logic [1:0]  occ_b;

  ifetch_queue #(.DEPTH(4), .ADDR_SHIFT(2)) dut_a (
    .Clk(Clk), .Reset(Reset), .IAddr(iaddr_a), .IRead(iread_a), .Inst(inst_a),
    .redirect(redirect), .redirect_target(redirect_target),
    .fetch_valid(fvalid_a), .fetch_ready(fetch_ready), .fetch_inst(finst_a),
    .fetch_pc(fpc_a), .occupancy(occ_a));

  ifetch_queue #(.DEPTH(2), .ADDR_SHIFT(0)) dut_b (
    .Clk(Clk), .Reset(Reset), .IAddr(iaddr_b), .IRead(iread_b), .Inst(inst_b),
    .redirect(redirect), .redirect_target(redirect_target),
    .fetch_valid(fvalid_b), .fetch_ready(fetch_ready), .fetch_inst(finst_b),
    .fetch_pc(fpc_b), .occupancy(occ_b));

  // Instruction memory: one-cycle read, content derived from the byte address.
  always @(posedge Clk) begin
    if (iread_a) inst_a <= (iaddr_a << 2) ^ 32'hA5A5A5A5;
    if (iread_b) inst_b <= iaddr_b ^ 32'hA5A5A5A5;
  end

  int n_cmp = 0, n_bad = 0, cyc = 0;
  bit checking = 0;

  task automatic chk(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d cyc %0d: got %h want %h", name, k, cyc, got, exp);
    end
  endtask

  // Reference: outstanding request (if any) plus a list of buffered {pc,inst}.
  typedef struct packed { logic [31:0] pc; logic [31:0] inst; } ent_t;
  ent_t        mq [2][$];
  logic [31:0] mpc [2];
  bit          mpend [2];
  logic [31:0] mpend_pc [2];

  function automatic int depth_of(input int k); return (k == 0) ? 4 : 2; endfunction
  function automatic int shift_of(input int k); return (k == 0) ? 2 : 0; endfunction
  function automatic bit may_issue(input int k);
    return !Reset && !redirect && (mq[k].size() + int'(mpend[k]) < depth_of(k));
  endfunction

  task automatic check_model();
    logic        ir, fv;
    logic [31:0] ia, fp, fi, oc;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin ir = iread_a; fv = fvalid_a; ia = iaddr_a; fp = fpc_a; fi = finst_a; oc = 32'(occ_a); end
      else        begin ir = iread_b; fv = fvalid_b; ia = iaddr_b; fp = fpc_b; fi = finst_b; oc = 32'(occ_b); end
      chk("m_iread", k, 32'(ir), 32'(may_issue(k)));
      chk("m_iaddr", k, ia, mpc[k] >> shift_of(k));
      chk("m_occ",   k, oc, 32'(mq[k].size()));
      chk("m_valid", k, 32'(fv), 32'(mq[k].size() != 0));
      if (mq[k].size() != 0) begin
        chk("m_pc",   k, fp, mq[k][0].pc);
        chk("m_inst", k, fi, mq[k][0].inst);
      end
    end
  endtask

  task automatic model_edge();
    bit ir;
    for (int k = 0; k < 2; k++) begin
      ir = may_issue(k);
      if (Reset) begin
        mq[k].delete(); mpend[k] = 0; mpc[k] = 32'h0;
      end else if (redirect) begin
        mq[k].delete(); mpend[k] = 0; mpc[k] = redirect_target & ~32'h3;
      end else begin
        if (mq[k].size() != 0 && fetch_ready) void'(mq[k].pop_front());
        if (mpend[k]) mq[k].push_back('{pc: mpend_pc[k], inst: mpend_pc[k] ^ 32'hA5A5A5A5});
        mpend[k] = ir;
        if (ir) begin mpend_pc[k] = mpc[k]; mpc[k] = mpc[k] + 32'd4; end
      end
    end
  endtask

  task automatic step();
    #1;
    if (checking) check_model();
    @(posedge Clk);
    model_edge();
    @(negedge Clk);
    cyc++;
  endtask

  task automatic set_in(input bit rst, input bit rd, input logic [31:0] tgt, input bit rdy);
    Reset = rst; redirect = rd; redirect_target = tgt; fetch_ready = rdy;
  endtask

  typedef struct {
    bit rst; bit redir; logic [31:0] tgt; bit rdy;
    bit e_iread; logic [31:0] e_iaddr; bit e_valid; int e_occ; logic [31:0] e_pc;
  } row_t;
  row_t tbl [19];

  int cnt;

  initial begin
    for (int k = 0; k < 2; k++) begin mpc[k] = 0; mpend[k] = 0; mpend_pc[k] = 0; end
    set_in(1, 0, 32'h0, 1);
    tbl = '{
      '{1,0,32'h0,  1, 0,32'h0,  0,0,32'h0},
      '{0,0,32'h0,  1, 1,32'h0,  0,0,32'h0},
      '{0,0,32'h0,  1, 1,32'h1,  0,0,32'h0},
      '{0,0,32'h0,  1, 1,32'h2,  1,1,32'h0},
      '{0,0,32'h0,  1, 1,32'h3,  1,1,32'h4},
      '{0,0,32'h0,  1, 1,32'h4,  1,1,32'h8},
      '{0,0,32'h0,  1, 1,32'h5,  1,1,32'hC},
      '{0,1,32'h100,1, 0,32'h0,  1,1,32'h10},
      '{0,0,32'h0,  1, 1,32'h40, 0,0,32'h0},
      '{0,0,32'h0,  1, 1,32'h41, 0,0,32'h0},
      '{0,0,32'h0,  1, 1,32'h42, 1,1,32'h100},
      '{0,0,32'h0,  1, 1,32'h43, 1,1,32'h104},
      '{0,0,32'h0,  0, 1,32'h44, 1,1,32'h108},
      '{0,0,32'h0,  0, 1,32'h45, 1,2,32'h108},
      '{0,0,32'h0,  0, 0,32'h0,  1,3,32'h108},
      '{0,0,32'h0,  0, 0,32'h0,  1,4,32'h108},
      '{0,0,32'h0,  1, 0,32'h0,  1,4,32'h108},
      '{0,0,32'h0,  1, 1,32'h46, 1,3,32'h10C},
      '{0,0,32'h0,  1, 1,32'h47, 1,2,32'h110}
    };
    @(negedge Clk);
    checking = 1;

    // Reset state of the head registers (still in reset).
    #1;
    chk("rst_finst", 0, finst_a, 32'h0); chk("rst_fpc", 0, fpc_a, 32'h0);
    chk("rst_finst", 1, finst_b, 32'h0); chk("rst_fpc", 1, fpc_b, 32'h0);

    // Directed table on the DEPTH=4 instance: stream, redirect, backpressure, drain.
    for (int i = 0; i < 19; i++) begin
      set_in(tbl[i].rst, tbl[i].redir, tbl[i].tgt, tbl[i].rdy);
      #1;
      chk("t_iread", 0, 32'(iread_a), 32'(tbl[i].e_iread));
      if (tbl[i].e_iread) chk("t_iaddr", 0, iaddr_a, tbl[i].e_iaddr);
      chk("t_valid", 0, 32'(fvalid_a), 32'(tbl[i].e_valid));
      chk("t_occ",   0, 32'(occ_a), 32'(tbl[i].e_occ));
      if (tbl[i].e_valid) begin
        chk("t_pc",   0, fpc_a, tbl[i].e_pc);
        chk("t_inst", 0, finst_a, tbl[i].e_pc ^ 32'hA5A5A5A5);
      end
      step();
    end

    // Fill, then redirect together with a pop: everything flushed, target low bits ignored.
    set_in(0, 0, 32'h0, 0);
    repeat (6) step();
    #1 chk("full_occ", 0, 32'(occ_a), 32'd4);
    set_in(0, 1, 32'h203, 1);
    step();
    set_in(0, 0, 32'h0, 1);
    #1;
    chk("flush_occ", 0, 32'(occ_a), 32'd0);
    chk("flush_iaddr", 0, iaddr_a, 32'h80);
    chk("flush_iaddr", 1, iaddr_b, 32'h200);
    step(); step();
    #1;
    chk("tgt_valid", 0, 32'(fvalid_a), 32'd1);
    chk("tgt_pc", 0, fpc_a, 32'h200);
    repeat (3) step();

    // One-cycle reset mid-stream with a read outstanding.
    #1 chk("pre_rst_iread", 0, 32'(iread_a), 32'd1);
    set_in(1, 0, 32'h0, 1);
    step();
    set_in(0, 0, 32'h0, 1);
    #1;
    chk("mrst_valid", 0, 32'(fvalid_a), 32'd0);
    chk("mrst_occ", 0, 32'(occ_a), 32'd0);
    chk("mrst_iaddr", 0, iaddr_a, 32'h0);
    step();
    #1 chk("mrst_stale", 0, 32'(occ_a), 32'd0);
    step();
    #1 chk("mrst_pc", 0, fpc_a, 32'h0);
    step();

    // Back-to-back redirects: last target wins.
    set_in(0, 1, 32'h300, 1); step();
    set_in(0, 1, 32'h400, 1); step();
    set_in(0, 0, 32'h0, 1);
    #1 chk("b2b_iaddr", 0, iaddr_a, 32'h100);
    step();
    #1 chk("b2b_valid", 0, 32'(fvalid_a), 32'd0);
    step();
    #1 chk("b2b_pc", 0, fpc_a, 32'h400);
    step();

    // PC wrap past the top of the address space.
    set_in(0, 1, 32'hFFFF_FFF8, 1); step();
    set_in(0, 0, 32'h0, 1);
    step(); step();
    #1 chk("wrap_pc0", 0, fpc_a, 32'hFFFF_FFF8); step();
    #1 chk("wrap_pc1", 0, fpc_a, 32'hFFFF_FFFC); step();
    #1 chk("wrap_pc2", 0, fpc_a, 32'h0000_0000); step();

    // DEPTH=2 cannot sustain one per cycle: bubbles must appear while streaming.
    set_in(1, 0, 32'h0, 1); step();
    set_in(0, 0, 32'h0, 1);
    repeat (4) step();
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      #1 if (fvalid_b) cnt++;
      step();
    end
    chk("b_bubble", 1, 32'(cnt > 0 && cnt < 12), 32'd1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] t;
      t = $urandom;
      if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      set_in($urandom_range(0, 199) == 0, $urandom_range(0, 24) == 0, t,
             $urandom_range(0, 3) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
